// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle add/sub/logic, WIDTH-step shift-add mul and restoring div
// Divider compiled in only when ALU_SEQ_DIV_EN is defined; otherwise op 100 completes at once with zero results.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               zero,
  output logic               negative,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef ALU_SEQ_DIV_EN
  logic             is_div;
`endif

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [WIDTH:0]     sub_mag;
  logic [2*WIDTH-1:0] sc_result;
  logic [WIDTH-1:0]   sc_rem;
  logic               sc_neg;
  logic               sc_dbz;
  logic               sc_multi;

  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {1'b0, a} - {1'b0, b};
    sub_mag   = sub_diff[WIDTH] ? ({1'b0, b} - {1'b0, a}) : sub_diff;
    sc_result = '0;
    sc_rem    = '0;
    sc_neg    = 1'b0;
    sc_dbz    = 1'b0;
    sc_multi  = 1'b0;
    case (op)
      3'b000: sc_result = {{(WIDTH-1){1'b0}}, add_sum};
      3'b001: begin
        sc_result = {{(WIDTH-1){1'b0}}, sub_mag};
        sc_neg    = sub_diff[WIDTH];
      end
      3'b010: sc_multi = 1'b1;
      3'b011: sc_result = {{WIDTH{1'b0}}, a & b};
`ifdef ALU_SEQ_DIV_EN
      3'b100: begin
        if (b == '0) begin
          sc_result = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          sc_rem    = a;
          sc_dbz    = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
`endif
      3'b101: sc_result = {{WIDTH{1'b0}}, a | b};
      3'b110: sc_result = {{WIDTH{1'b0}}, a ^ b};
      default: sc_result = '0;
    endcase
  end

  // hi:lo is the product accumulator for mul, remainder:quotient shift pair for div
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] fin_result;
  logic [WIDTH-1:0]   fin_rem;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
`endif

  always_comb begin
    mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    step_hi    = mul_sum[WIDTH:1];
    step_lo    = {mul_sum[0], lo[WIDTH-1:1]};
    fin_result = {step_hi, step_lo};
    fin_rem    = '0;
`ifdef ALU_SEQ_DIV_EN
    div_shift  = {hi, lo[WIDTH-1]};
    div_trial  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end
      fin_result = {{WIDTH{1'b0}}, step_lo};
      fin_rem    = step_hi;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
`ifdef ALU_SEQ_DIV_EN
      is_div      <= 1'b0;
`endif
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      zero        <= 1'b0;
      negative    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (sc_multi) begin
              state <= CALC;
              hi    <= '0;
`ifdef ALU_SEQ_DIV_EN
              is_div <= (op == 3'b100);
              opnd   <= (op == 3'b100) ? b : a;
              lo     <= (op == 3'b100) ? a : b;
`else
              opnd <= a;
              lo   <= b;
`endif
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              result      <= sc_result;
              remainder   <= sc_rem;
              zero        <= (sc_result == '0);
              negative    <= sc_neg;
              div_by_zero <= sc_dbz;
            end
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state       <= DONE;
            done        <= 1'b1;
            result      <= fin_result;
            remainder   <= fin_rem;
            zero        <= (fin_result == '0);
            negative    <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed bench for alu_seq (WIDTH=8) with a cycle-level reference model
// Honours ALU_SEQ_DIV_EN the same way the design does.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [2*W-1:0] result;
  logic [W-1:0] remainder;
  logic         zero;
  logic         negative;
  logic         div_by_zero;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .remainder(remainder),
    .zero(zero), .negative(negative), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [7:0]  rm;
    logic        z;
    logic        ng;
    logic        dz;
    logic [4:0]  lat;
  } exp_t;

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int ux;
    int uy;
    ux = int'(x);
    uy = int'(y);
    e = '0;
    e.lat = 5'd1;
    case (o)
      3'd0: e.r = 16'(ux + uy);
      3'd1: begin
        if (ux < uy) begin
          e.r  = 16'(uy - ux);
          e.ng = 1'b1;
        end else begin
          e.r = 16'(ux - uy);
        end
      end
      3'd2: begin
        e.r   = 16'(ux * uy);
        e.lat = 5'(W + 1);
      end
      3'd3: e.r = {8'h00, x & y};
`ifdef ALU_SEQ_DIV_EN
      3'd4: begin
        if (uy == 0) begin
          e.r  = 16'h00FF;
          e.rm = x;
          e.dz = 1'b1;
        end else begin
          e.r   = 16'(ux / uy);
          e.rm  = 8'(ux % uy);
          e.lat = 5'(W + 1);
        end
      end
`endif
      3'd5: e.r = {8'h00, x | y};
      3'd6: e.r = {8'h00, x ^ y};
      default: e.r = 16'h0000;
    endcase
    e.z = (e.r == 16'h0000);
    return e;
  endfunction

  // left counts cycles until the operation in flight retires; 1 means the done cycle
  int   left = 0;
  exp_t pend = '0;
  exp_t cur  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left <= 0;
      pend <= '0;
      cur  <= '0;
    end else if (left == 0) begin
      if (start) begin
        pend <= model(op, a, b);
        left <= int'(model(op, a, b).lat);
        if (model(op, a, b).lat == 5'd1) cur <= model(op, a, b);
      end
    end else begin
      left <= left - 1;
      if (left == 2) cur <= pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(left != 0));
      check("done", 32'(done), 32'(left == 1));
      check("result", 32'(result), 32'(cur.r));
      check("remainder", 32'(remainder), 32'(cur.rm));
      check("zero", 32'(zero), 32'(cur.z));
      check("negative", 32'(negative), 32'(cur.ng));
      check("div_by_zero", 32'(div_by_zero), 32'(cur.dz));
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int bc);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bc  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
    end
    if (!done) $display("FAIL run_op timeout: op %0d got no done within 40 cycles", o);
  endtask

  typedef struct packed {
    logic [2:0] o;
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [10] = '{
    '{3'd3, 8'hF0, 8'h3C}, '{3'd5, 8'hF0, 8'h0F}, '{3'd6, 8'hAA, 8'hFF},
    '{3'd7, 8'h12, 8'h34}, '{3'd2, 8'd255, 8'd255}, '{3'd1, 8'd9, 8'd5},
    '{3'd1, 8'd7, 8'd7}, '{3'd4, 8'd255, 8'd1}, '{3'd4, 8'd0, 8'd5},
    '{3'd2, 8'd0, 8'd77}
  };

  initial begin
    int lat;
    int bc;
    int dn;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op(3'd0, 8'd255, 8'd1, lat, bc);
    check("add_lat", 32'(lat), 32'd1);
    check("add_result", 32'(result), 32'h0100);
    check("add_zero", 32'(zero), 32'd0);

    run_op(3'd1, 8'd5, 8'd9, lat, bc);
    check("sub_result", 32'(result), 32'd4);
    check("sub_negative", 32'(negative), 32'd1);

    run_op(3'd2, 8'd200, 8'd3, lat, bc);
    check("mul_lat", 32'(lat), 32'd9);
    check("mul_result", 32'(result), 32'h0258);
    check("mul_busy_cycles", 32'(bc), 32'd9);

`ifdef ALU_SEQ_DIV_EN
    run_op(3'd4, 8'd200, 8'd7, lat, bc);
    check("div_lat", 32'(lat), 32'd9);
    check("div_result", 32'(result), 32'd28);
    check("div_remainder", 32'(remainder), 32'd4);

    run_op(3'd4, 8'd37, 8'd0, lat, bc);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_result", 32'(result), 32'h00FF);
    check("div0_remainder", 32'(remainder), 32'h25);
    check("div0_flag", 32'(div_by_zero), 32'd1);
`else
    run_op(3'd4, 8'd200, 8'd7, lat, bc);
    check("nodiv_lat", 32'(lat), 32'd1);
    check("nodiv_result", 32'(result), 32'd0);
    check("nodiv_flag", 32'(div_by_zero), 32'd0);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].o, vecs[i].x, vecs[i].y, lat, bc);
      check("vec_lat", 32'(lat), 32'(model(vecs[i].o, vecs[i].x, vecs[i].y).lat));
      if (i == 1) check("or_result", 32'(result), 32'h00FF);
      if (i == 3) check("reserved_zero", 32'(zero), 32'd1);
      if (i == 4) check("mul_max", 32'(result), 32'hFE01);
      if (i == 6) check("sub_equal_zero", 32'(zero), 32'd1);
    end

    // second start during CALC and during DONE must both be ignored
    @(negedge clk);
    op = 3'd2; a = 8'd200; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 14; k++) begin
      if (done) dn++;
      if (k == 3 || k == 9) begin
        op = 3'd0; a = 8'd1; b = 8'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("repulse_done_count", 32'(dn), 32'd1);
    check("repulse_result", 32'(result), 32'h0258);

    // reset in the 4th CALC cycle of a divide
    @(negedge clk);
    op = 3'd4; a = 8'd200; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({remainder, zero, negative, div_by_zero}), 32'd0);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst = 1'b0;
    op = 3'd0; a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_result", 32'(result), 32'd7);
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("aborted_no_done", 32'(dn), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
